// File: rtl/maroc_sc_loader.sv
// rtl/maroc_sc_loader.sv - MAROC slow-control loader: byte stream to 829-bit frame, then load/shift/done sequencing
module maroc_sc_loader #(
  parameter int FRAME_BITS = 829,
  parameter int NBYTES     = 104
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  abort,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  load,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  localparam logic [2:0] ST_RECV    = 3'd0;
  localparam logic [2:0] ST_DISCARD = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Only the low LAST_BITS of the final byte land in the frame.
  localparam int         LAST_BITS = FRAME_BITS - 8 * (NBYTES - 1);
  localparam logic [6:0] BCNT_MAX  = 7'(NBYTES - 1);
  localparam logic [9:0] SCNT_MAX  = 10'(FRAME_BITS - 1);

  logic [2:0]            state_q, state_d;
  logic [6:0]            bcnt_q, bcnt_d;
  logic [9:0]            scnt_q, scnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  load_q, load_d;
  logic                  shift_en_q, shift_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_len_q, err_len_d;
  logic                  accept;

  assign s_ready = (state_q == ST_RECV) || (state_q == ST_DISCARD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    frame_d   = frame_q;
    err_len_d = 1'b0;
    case (state_q)
      ST_RECV: begin
        if (accept) begin
          for (int k = 0; k < NBYTES - 1; k++) begin
            if (bcnt_q == 7'(k)) frame_d[8*k +: 8] = s_data;
          end
          if (bcnt_q == BCNT_MAX) begin
            frame_d[FRAME_BITS-1 -: LAST_BITS] = s_data[LAST_BITS-1:0];
            bcnt_d = '0;
            if (s_last) begin
              state_d = ST_LOAD;
            end else begin
              err_len_d = 1'b1;
              state_d   = ST_DISCARD;
            end
          end else if (s_last) begin
            err_len_d = 1'b1;
            bcnt_d    = '0;
          end else begin
            bcnt_d = bcnt_q + 7'd1;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) state_d = ST_RECV;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        scnt_d  = '0;
      end
      ST_SHIFT: begin
        if (scnt_q == SCNT_MAX) begin
          state_d = ST_DONE;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 10'd1;
        end
      end
      ST_DONE: state_d = ST_RECV;
      default: state_d = ST_RECV;
    endcase

    // Abort wins over everything, including a byte accepted on the same edge.
    if (abort) begin
      state_d   = ST_RECV;
      bcnt_d    = '0;
      scnt_d    = '0;
      frame_d   = frame_q;
      err_len_d = 1'b0;
    end

    load_d     = (state_d == ST_LOAD);
    shift_en_d = (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
    busy_d     = load_d || shift_en_d || done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RECV;
      bcnt_q     <= '0;
      scnt_q     <= '0;
      frame_q    <= '0;
      load_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      scnt_q     <= scnt_d;
      frame_q    <= frame_d;
      load_q     <= load_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
    end
  end

  assign frame    = frame_q;
  assign load     = load_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_len  = err_len_q;

endmodule

// File: tb/tb_maroc_sc_loader.sv
// tb/tb_maroc_sc_loader.sv - self-checking bench for maroc_sc_loader
module tb_maroc_sc_loader;
  localparam int FB = 829;
  localparam int NB = 104;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          abort = 1'b0;
  logic          s_ready;
  logic [FB-1:0] frame;
  logic          load, shift_en, busy, done, err_len;

  maroc_sc_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .frame(frame), .load(load),
    .shift_en(shift_en), .busy(busy), .done(done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int load_tot = 0, err_tot = 0, done_tot = 0, shift_tot = 0;
  int load_cyc = 0, done_cyc = 0, first_sh = 0, last_sh = 0;
  logic sh_prev = 1'b0;
  always @(negedge clk) begin
    if (load) begin load_tot++; load_cyc = cyc; end
    if (err_len) err_tot++;
    if (done) begin done_tot++; done_cyc = cyc; end
    if (shift_en) begin
      if (!sh_prev) first_sh = cyc;
      shift_tot++;
      last_sh = cyc;
    end
    sh_prev = shift_en;
  end

  int checks = 0, failures = 0;
  int last_acc = 0;
  logic [FB-1:0] exp_frame = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name);
    checks++;
    if (frame !== exp_frame) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, frame, exp_frame);
    end
  endtask

  task automatic model_byte(input int idx, input logic [7:0] d);
    if (idx < NB - 1) exp_frame[8*idx +: 8] = d;
    else if (idx == NB - 1) exp_frame[FB-1 -: 5] = d[4:0];
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    while (!s_ready && w < 2000) begin @(negedge clk); w++; end
    if (!s_ready) begin
      failures++; checks++;
      $display("FAIL send_timeout: got s_ready=0 expected 1");
    end
    last_acc = cyc;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'(base + i);
      send_byte(d, i == n - 1);
      model_byte(i, d);
    end
  endtask

  task automatic wait_sig_load();
    int w;
    w = 0;
    while (!load && w < 100) begin @(negedge clk); w++; end
    chk("load_seen", longint'(load), 1);
  endtask

  typedef struct {
    int nbytes;
    int base;
    int exp_err;
    int exp_load;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int e0, l0, d0, s0, w, acc0;
    vecs[0] = '{104, 8'h00, 0, 1};
    vecs[1] = '{51,  8'h80, 1, 0};
    vecs[2] = '{104, 8'h10, 0, 1};
    vecs[3] = '{110, 8'h20, 1, 0};
    vecs[4] = '{1,   8'h55, 1, 0};
    vecs[5] = '{104, 8'hA0, 0, 1};

    @(negedge clk); @(negedge clk);
    chk("rst_s_ready", longint'(s_ready), 1);
    chk("rst_load", longint'(load), 0);
    chk("rst_shift_en", longint'(shift_en), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err_len", longint'(err_len), 0);
    chk_frame("rst_frame");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      e0 = err_tot; l0 = load_tot; d0 = done_tot; s0 = shift_tot;
      send_frame(vecs[v].nbytes, vecs[v].base);
      if (vecs[v].exp_load != 0) begin
        w = 0;
        while (!done && w < 1000) begin @(negedge clk); w++; end
        @(negedge clk);
        chk("load_latency", load_cyc - last_acc, 1);
        chk("shift_first", first_sh - last_acc, 2);
        chk("shift_last", last_sh - last_acc, 830);
        chk("shift_cycles", shift_tot - s0, 829);
        chk("done_latency", done_cyc - last_acc, 831);
      end else begin
        repeat (4) @(negedge clk);
      end
      chk("vec_err_count", err_tot - e0, vecs[v].exp_err);
      chk("vec_load_count", load_tot - l0, vecs[v].exp_load);
      chk("vec_done_count", done_tot - d0, vecs[v].exp_load);
      chk("vec_s_ready", longint'(s_ready), 1);
      chk_frame("vec_frame");
      if (v == 0) begin
        chk("frame_byte0", longint'(frame[7:0]), 8'h00);
        chk("frame_byte1", longint'(frame[15:8]), 8'h01);
        chk("frame_top5", longint'(frame[828:824]), 5'h07);
      end
    end

    // Back-pressure: a byte held during SHIFT is taken the cycle after done.
    send_frame(104, 8'h30);
    acc0 = last_acc;
    send_byte(8'hEE, 1'b0);
    model_byte(0, 8'hEE);
    chk("bp_accept_gap", last_acc - acc0, 832);
    chk("bp_after_done", last_acc - done_cyc, 1);
    chk_frame("bp_frame");
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Abort in the middle of SHIFT.
    d0 = done_tot; l0 = load_tot;
    send_frame(104, 8'h40);
    wait_sig_load();
    repeat (400) @(negedge clk);
    chk("abort_pre_shift", longint'(shift_en), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_shift_en", longint'(shift_en), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_s_ready", longint'(s_ready), 1);
    repeat (900) @(negedge clk);
    chk("abort_no_done", done_tot - d0, 0);
    chk("abort_one_load", load_tot - l0, 1);
    chk_frame("abort_frame");

    // Asynchronous reset in the middle of SHIFT.
    d0 = done_tot;
    send_frame(104, 8'h50);
    wait_sig_load();
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_frame = '0;
    chk("arst_shift_en", longint'(shift_en), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_load", longint'(load), 0);
    chk("arst_done", longint'(done), 0);
    chk("arst_err_len", longint'(err_len), 0);
    chk("arst_s_ready", longint'(s_ready), 1);
    chk_frame("arst_frame");
    @(negedge clk);
    rst = 1'b0;
    repeat (900) @(negedge clk);
    chk("arst_no_done", done_tot - d0, 0);

    // Recovery frame after reset.
    d0 = done_tot;
    send_frame(104, 8'h60);
    w = 0;
    while (!done && w < 1000) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("recover_done", done_tot - d0, 1);
    chk("recover_done_latency", done_cyc - last_acc, 831);
    chk_frame("recover_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/maroc_sc_loader.md
# maroc_sc_loader

Upstream stage of the MAROC slow-control transmitter. Accepts the 829-bit slow-control frame as a byte stream from the host interface and assembles it into a parallel frame register. It then sequences the transmitter: a one-cycle load strobe, followed by exactly 829 shift-enable cycles, then a completion pulse. Length errors in the byte stream are detected and the bad frame is discarded.

## Interface
- FRAME_BITS, 829, slow-control frame length in bits.
- NBYTES, 104, bytes per frame, equal to ceil(FRAME_BITS/8).
- clk  in  1  system clock; also the transmitter's CK_in.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  8  frame byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final byte of a frame; qualified by s_valid.
- s_ready  out  1  byte accepted when s_valid && s_ready at the clk rising edge.
- abort  in  1  synchronous; returns the block to RECV from any state.
- frame  out  FRAME_BITS  assembled frame, connected to the transmitter's parallel inputs.
- load  out  1  one-cycle strobe to the transmitter's state input.
- shift_en  out  1  high while the transmitter must shift.
- busy  out  1  high in LOAD, SHIFT and DONE.
- done  out  1  one-cycle pulse after the last shift cycle.
- err_len  out  1  one-cycle pulse on a frame-length error.

## Operation
- Byte mapping: byte k is written to frame[8k+7:8k] for k = 0..102.
  - Byte 103 bits [4:0] go to frame[828:824]; bits [7:5] are ignored.
  - Frame bit 0 (ON_OFF_otabg) therefore arrives first.
- Byte counter bcnt is 7 bits, range 0..103. Bit counter scnt is 10 bits, range 0..828.
- RECV: s_ready=1.
  - Each accepted byte is written at index bcnt, then bcnt increments.
  - Accepted byte with s_last and bcnt==103: go to LOAD and clear bcnt.
  - Accepted byte with s_last and bcnt<103: pulse err_len, clear bcnt, stay in RECV.
  - Accepted byte with bcnt==103 and no s_last: pulse err_len, clear bcnt, go to DISCARD.
- DISCARD: s_ready=1. Bytes are accepted and dropped. The byte carrying s_last returns the block to RECV and produces no further err_len.
- LOAD: load=1 for one cycle, then go to SHIFT with scnt=0.
- SHIFT: shift_en=1.
  - scnt increments every cycle.
  - When scnt==828, go to DONE, so shift_en is high for exactly 829 cycles.
- DONE: done=1 for one cycle, then go to RECV.
- s_ready=0 in LOAD, SHIFT and DONE. Input bytes are back-pressured, never dropped.
- frame is written only in RECV. It holds unchanged from LOAD through DONE and afterwards until overwritten by the next frame.
  - A discarded or erroneous partial frame leaves partially overwritten bits in frame. No load is issued for it.
- abort has priority over all other transitions.
  - Next state is RECV with bcnt=0 and scnt=0.
  - load, shift_en, done and err_len are 0 from the next cycle.
  - frame contents are retained.
- Simultaneous abort and accepted byte: the byte is dropped.

## Timing
- Reset values: state RECV, s_ready=1, frame=0, load=0, shift_en=0, busy=0, done=0, err_len=0, bcnt=0, scnt=0.
- rst asserted mid-SHIFT drops shift_en immediately (asynchronous); no done is produced.
- All outputs except s_ready are registered on the clk rising edge. s_ready is decoded from the state register.
- Latency: last byte accepted at edge N gives load=1 in cycle N+1, shift_en in cycles N+2..N+830, and done in cycle N+831.
- Next frame bytes are accepted from cycle N+832.
- frame and load change only on rising edges, so they are stable at the transmitter's falling-edge sample point.
- Throughput: one byte per cycle in RECV and DISCARD.

## Test plan
- Reset, then 104 bytes with values 0x00..0x67 and s_last on the final byte.
  - Expect frame[7:0]=0x00, frame[15:8]=0x01 and frame[828:824]=0x67&0x1F.
  - Expect load exactly 1 cycle after the last byte, shift_en high for 829 cycles, and done 831 cycles after the last byte.
- s_last on byte 50 → err_len pulse, no load. A following good 104-byte frame completes normally.
- 110 bytes with s_last on the 110th → err_len once at byte 104, bytes 105..110 dropped, no load. The block is back in RECV.
- s_valid held high during SHIFT → s_ready=0 and no byte consumed. The first pending byte is accepted 1 cycle after done.
- abort at SHIFT cycle 400 → shift_en=0 next cycle, no done, and frame unchanged.
- rst asserted at SHIFT cycle 100 → all outputs at reset values immediately, frame=0, and s_ready=1.
